// File: rtl/riscv_cpu_pkg.sv
// riscv_cpu_pkg: shared widths and opcode encodings for the riscv_cpu execute unit
package riscv_cpu_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_SLL  = 4'h2;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OP_W-1:0] OP_OR   = 4'h6;
  localparam logic [OP_W-1:0] OP_SLTU = 4'h7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'h8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'h9;
  localparam logic [OP_W-1:0] OP_MUL  = 4'hA;
  typedef enum logic [OP_W-1:0] {
    ADD = OP_ADD, SUB = OP_SUB, SLL = OP_SLL, SLT = OP_SLT,
    AND = OP_AND, XOR = OP_XOR, OR = OP_OR, SLTU = OP_SLTU,
    SRL = OP_SRL, SRA = OP_SRA, MUL = OP_MUL
  } opcode_e;
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational ALU; MUL decoded only when RISCV_CPU_MUL_EN is defined
module riscv_alu
  import riscv_cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  opcode_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [3:0] sh;
  assign sh = b[3:0];
  always_comb begin
    y = '0;
    case (op)
      ADD:  y = a + b;
      SUB:  y = a - b;
      SLL:  y = a << sh;
      SLT:  y = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      AND:  y = a & b;
      XOR:  y = a ^ b;
      OR:   y = a | b;
      SLTU: y = {{(W-1){1'b0}}, a < b};
      SRL:  y = a >> sh;
      SRA:  y = $signed(a) >>> sh;
`ifdef RISCV_CPU_MUL_EN
      MUL:  y = a * b;
`endif
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/riscv_cpu.sv
// riscv_cpu: registered 16-bit execute unit (opt. MUL via RISCV_CPU_MUL_EN)
module riscv_cpu
  import riscv_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag
);
  logic [DATA_W-1:0] y;
  logic unused_bits;
  assign unused_bits = ^instruction[15:OP_W];
  riscv_alu #(.W(DATA_W)) alu (
    .op(opcode_e'(instruction[OP_W-1:0])),
    .a(operand1),
    .b(operand2),
    .y(y)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      zero_flag <= 1'b0;
    end else begin
      result    <= y;
      zero_flag <= y == '0;
    end
  end
endmodule

// File: tb/tb_riscv_cpu.sv
// tb_riscv_cpu: directed and randomized checks of riscv_cpu against an arithmetic model
module tb_riscv_cpu;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] instruction, operand1, operand2, result;
  logic zero_flag;
  int total = 0;
  int passed = 0;

  always #1 clk = ~clk;

  riscv_cpu dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .operand1(operand1), .operand2(operand2),
    .result(result), .zero_flag(zero_flag)
  );

  function automatic logic [15:0] model(input int op, input longint a, input longint b);
    longint sa, sb, p, r;
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    p = longint'(1) << (b % 16);
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a - b + 65536) % 65536;
      2: r = (a * p) % 65536;
      3: r = sa < sb ? 1 : 0;
      4: r = a & b;
      5: r = a ^ b;
      6: r = a | b;
      7: r = a < b ? 1 : 0;
      8: r = a / p;
      9: r = (sa >= 0 ? sa / p : -((-sa + p - 1) / p)) + 65536;
`ifdef RISCV_CPU_MUL_EN
      10: r = (a * b) % 65536;
`endif
      default: r = 0;
    endcase
    return 16'(r % 65536);
  endfunction

  task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    instruction = {12'($urandom), op};
    operand1 = a;
    operand2 = b;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(4'h0, 16'd4, 16'd3);
      total++;
      if (result !== 16'h0000 || zero_flag !== 1'b0)
        $display("FAIL reset[%0d]: got %h z=%b, want 0000 z=0", i, result, zero_flag);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [3:0]  ops [18] = '{4'h0, 4'h1, 4'h1, 4'h4, 4'h6, 4'h5, 4'h0, 4'h1, 4'h3, 4'h7,
                             4'h2, 4'h8, 4'h9, 4'hF, 4'hA, 4'h3, 4'h9, 4'h7};
    logic [15:0] as [18] = '{16'h4, 16'h4, 16'h3, 16'h5, 16'h5, 16'h5, 16'hFFFF, 16'h3, 16'hFFFF,
                             16'hFFFF, 16'h1, 16'h8000, 16'h8000, 16'h1234, 16'h3, 16'h1,
                             16'h7000, 16'h1};
    logic [15:0] bs [18] = '{16'h3, 16'h3, 16'h3, 16'h6, 16'h6, 16'h6, 16'h1, 16'h4, 16'h1,
                             16'h1, 16'h4, 16'hF, 16'hF, 16'h5678, 16'h5, 16'hFFFF,
                             16'h0014, 16'h1};
`ifdef RISCV_CPU_MUL_EN
    logic [15:0] mul_exp = 16'h000F;
`else
    logic [15:0] mul_exp = 16'h0000;
`endif
    logic [15:0] ex [18];
    ex = '{16'h7, 16'h1, 16'h0, 16'h4, 16'h7, 16'h3, 16'h0, 16'hFFFF, 16'h1, 16'h0,
           16'h10, 16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0700, 16'h0};
    ex[14] = mul_exp;
    for (int i = 0; i < 18; i++) begin
      step(ops[i], as[i], bs[i]);
      total++;
      if (result !== ex[i] || zero_flag !== (ex[i] == 16'h0))
        $display("FAIL directed[%0d] op=%h %h,%h: got %h z=%b, want %h z=%b",
                 i, ops[i], as[i], bs[i], result, zero_flag, ex[i], ex[i] == 16'h0);
      else passed++;
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [15:0] a, b, e;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a = (i % 7 == 0) ? 16'h8000 | 16'($urandom) : 16'($urandom);
      b = (i % 11 == 0) ? a : 16'($urandom);
      e = model(int'(op), longint'(a), longint'(b));
      step(op, a, b);
      total++;
      if (result !== e || zero_flag !== (e == 16'h0))
        $display("FAIL random[%0d] op=%h %h,%h: got %h z=%b, want %h z=%b",
                 i, op, a, b, result, zero_flag, e, e == 16'h0);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    step(4'h0, 16'h0010, 16'h0020);
    total++;
    if (result !== 16'h0030 || zero_flag !== 1'b0)
      $display("FAIL pre_reset: got %h z=%b, want 0030 z=0", result, zero_flag);
    else passed++;
    reset = 1'b1;
    step(4'h0, 16'd4, 16'd3);
    reset = 1'b0;
    total++;
    if (result !== 16'h0000 || zero_flag !== 1'b0)
      $display("FAIL reset_mid: got %h z=%b, want 0000 z=0", result, zero_flag);
    else passed++;
    step(4'h1, 16'h0003, 16'h0003);
    total++;
    if (result !== 16'h0000 || zero_flag !== 1'b1)
      $display("FAIL post_reset: got %h z=%b, want 0000 z=1", result, zero_flag);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    instruction = '0;
    operand1 = '0;
    operand2 = '0;
    test_reset;
    test_directed;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
